// File: rtl/bin2bcd_target_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per clock)
// with a registered tolerance compare against a target value. Feeds the
// three-digit seven-segment decoder's Data_in and target_reached inputs.
module bin2bcd_target_seq #(
  parameter int unsigned BIN_W = 10,
  parameter int unsigned TOL   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  input  logic [BIN_W-1:0] bin_in,
  input  logic [BIN_W-1:0] target_in,
  output logic             busy,
  output logic             done,
  output logic [11:0]      bcd_out,
  output logic             target_reached,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [BIN_W-1:0] shreg;
  logic [BIN_W-1:0] bin_lat;
  logic [BIN_W-1:0] tgt_lat;
  logic [19:0]      scratch;
  logic [19:0]      scratch_adj;
  logic [4:0]       cnt;
  logic [BIN_W:0]   diff;
  logic             in_tol;
  logic             too_big;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (valid_in) state_nxt = SHIFT;
      SHIFT:   if (cnt == 5'd1) state_nxt = LOAD;
      LOAD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Add-3 correction on every BCD scratch digit that is 5 or more
  always_comb begin
    scratch_adj = scratch;
    for (int unsigned d = 0; d < 5; d++) begin
      if (scratch[4*d +: 4] >= 4'd5)
        scratch_adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
    end
  end

  // Unsigned magnitude of bin - target on BIN_W+1 bits, compared to TOL
  always_comb begin
    if (bin_lat >= tgt_lat) diff = {1'b0, bin_lat} - {1'b0, tgt_lat};
    else                    diff = {1'b0, tgt_lat} - {1'b0, bin_lat};
    in_tol  = (32'(diff) <= TOL);
    too_big = (32'(bin_lat) > 32'd999);
  end

  assign busy = (state != IDLE);

  // Operand latch, shift datapath and registered results
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg          <= '0;
      bin_lat        <= '0;
      tgt_lat        <= '0;
      scratch        <= '0;
      cnt            <= '0;
      done           <= 1'b0;
      bcd_out        <= '0;
      target_reached <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_in) begin
            shreg   <= bin_in;
            bin_lat <= bin_in;
            tgt_lat <= target_in;
            scratch <= '0;
            cnt     <= 5'(BIN_W);
          end
        end
        SHIFT: begin
          {scratch, shreg} <= {scratch_adj, shreg} << 1;
          cnt              <= cnt - 5'd1;
        end
        LOAD: begin
          if (too_big) begin
            bcd_out  <= 12'hEEE;
            overflow <= 1'b1;
          end else begin
            bcd_out  <= scratch[11:0];
            overflow <= 1'b0;
          end
          target_reached <= in_tol;
          done           <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin2bcd_target_seq.sv
// Directed testbench for bin2bcd_target_seq: one instance with TOL=0 and
// one with TOL=3 share the same stimulus.
module tb_bin2bcd_target_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic       valid_in;
  logic [9:0] bin_in;
  logic [9:0] target_in;

  logic        busy0, done0, tr0, ov0;
  logic [11:0] bcd0;
  logic        busy3, done3, tr3, ov3;
  logic [11:0] bcd3;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bin2bcd_target_seq #(.BIN_W(10), .TOL(0)) u_tol0 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .bin_in(bin_in),
    .target_in(target_in), .busy(busy0), .done(done0), .bcd_out(bcd0),
    .target_reached(tr0), .overflow(ov0)
  );

  bin2bcd_target_seq #(.BIN_W(10), .TOL(3)) u_tol3 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .bin_in(bin_in),
    .target_in(target_in), .busy(busy3), .done(done3), .bcd_out(bcd3),
    .target_reached(tr3), .overflow(ov3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one request; returns at the negedge just after the accepting edge
  task automatic start(input logic [9:0] b, input logic [9:0] t);
    @(negedge clk);
    valid_in  = 1'b1;
    bin_in    = b;
    target_in = t;
    @(negedge clk);
    valid_in  = 1'b0;
  endtask

  // Waits (bounded) for done; lat counts negedges since the accepting edge
  task automatic wait_done(input int j0, output int lat, output int bcnt);
    int j;
    j    = j0;
    bcnt = 0;
    while (done0 !== 1'b1 && j < 40) begin
      if (busy0 === 1'b1) bcnt++;
      @(negedge clk);
      j++;
    end
    lat = j;
  endtask

  task automatic count_done(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) pulses++;
    end
  endtask

  initial begin
    int lat, bcnt, pulses;
    reset     = 1'b1;
    valid_in  = 1'b0;
    bin_in    = '0;
    target_in = '0;
    #12;
    chk("reset_bcd",  bcd0, 32'h000);
    chk("reset_busy", busy0, 0);
    chk("reset_done", done0, 0);
    chk("reset_tr",   tr0, 0);
    chk("reset_ov",   ov0, 0);
    @(negedge clk);
    reset = 1'b0;

    // Zero against zero target
    start(10'd0, 10'd0);
    wait_done(0, lat, bcnt);
    chk("zero_latency", lat, 11);
    chk("zero_bcd", bcd0, 32'h000);
    chk("zero_tr",  tr0, 1);
    chk("zero_ov",  ov0, 0);

    // Largest in-range value, busy window and single done pulse
    start(10'd999, 10'd500);
    wait_done(0, lat, bcnt);
    chk("b999_latency", lat, 11);
    chk("b999_busy_cycles", bcnt, 11);
    chk("b999_bcd", bcd0, 32'h999);
    chk("b999_tr",  tr0, 0);
    count_done(3, pulses);
    chk("b999_single_done", pulses, 0);

    start(10'd407, 10'd407);
    wait_done(0, lat, bcnt);
    chk("b407_bcd", bcd0, 32'h407);
    chk("b407_tr",  tr0, 1);
    // Outputs hold while idle inputs wander
    bin_in = 10'd12; target_in = 10'd900;
    repeat (5) @(negedge clk);
    chk("hold_bcd", bcd0, 32'h407);
    chk("hold_tr",  tr0, 1);

    // Overflow handling
    start(10'd1000, 10'd0);
    wait_done(0, lat, bcnt);
    chk("b1000_bcd", bcd0, 32'hEEE);
    chk("b1000_ov",  ov0, 1);
    start(10'd1023, 10'd0);
    wait_done(0, lat, bcnt);
    chk("b1023_bcd", bcd0, 32'hEEE);
    chk("b1023_ov",  ov0, 1);
    chk("b1023_ov_tol3", ov3, 1);
    chk("b1023_tr_wide_diff", tr0, 0);
    start(10'd5, 10'd1023);
    wait_done(0, lat, bcnt);
    chk("b5_bcd", bcd0, 32'h005);
    chk("b5_ov",  ov0, 0);
    chk("b5_tr",  tr0, 0);

    // Tolerance window with TOL=3 around 100
    start(10'd97, 10'd100);
    wait_done(0, lat, bcnt);
    chk("t97_tr3", tr3, 1);
    chk("t97_tr0", tr0, 0);
    chk("t97_bcd3", bcd3, 32'h097);
    start(10'd103, 10'd100);
    wait_done(0, lat, bcnt);
    chk("t103_tr3", tr3, 1);
    start(10'd104, 10'd100);
    wait_done(0, lat, bcnt);
    chk("t104_tr3", tr3, 0);
    start(10'd96, 10'd100);
    wait_done(0, lat, bcnt);
    chk("t96_tr3", tr3, 0);
    start(10'd100, 10'd100);
    wait_done(0, lat, bcnt);
    chk("t100_tr0", tr0, 1);
    chk("t100_done3", done3, 1);

    // valid_in during busy is ignored
    start(10'd123, 10'd0);
    repeat (5) @(negedge clk);
    valid_in = 1'b1; bin_in = 10'd456; target_in = 10'd456;
    @(negedge clk);
    valid_in = 1'b0;
    wait_done(6, lat, bcnt);
    chk("ign_latency", lat, 11);
    chk("ign_bcd", bcd0, 32'h123);
    chk("ign_tr",  tr0, 0);
    count_done(15, pulses);
    chk("ign_no_second_done", pulses, 0);

    // valid_in in the done cycle is accepted
    start(10'd123, 10'd0);
    wait_done(0, lat, bcnt);
    chk("back_first_bcd", bcd0, 32'h123);
    valid_in = 1'b1; bin_in = 10'd456; target_in = 10'd456;
    @(negedge clk);
    valid_in = 1'b0;
    wait_done(0, lat, bcnt);
    chk("back_latency", lat, 11);
    chk("back_bcd", bcd0, 32'h456);
    chk("back_tr",  tr0, 1);

    // Asynchronous reset mid-conversion
    start(10'd321, 10'd0);
    repeat (6) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("arst_bcd",  bcd0, 32'h000);
    chk("arst_tr",   tr0, 0);
    chk("arst_busy", busy0, 0);
    chk("arst_busy3", busy3, 0);
    chk("arst_ov",   ov0, 0);
    @(negedge clk);
    reset = 1'b0;
    count_done(15, pulses);
    chk("arst_no_done", pulses, 0);
    chk("arst_bcd_held", bcd0, 32'h000);
    start(10'd88, 10'd0);
    wait_done(0, lat, bcnt);
    chk("after_rst_latency", lat, 11);
    chk("after_rst_bcd", bcd0, 32'h088);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
